// File: rtl/alu_exec_ctrl_if.sv
// Purpose: request, ALU-side and writeback-status bundle for alu_exec_ctrl.
// Latency: wires only, no state.
// Backpressure: req_valid/req_ready handshake; a request is taken when both are high.
// Ports: req_* (operation request), alu_A/alu_B/alu_ctrl (operands to the ALU),
//   alu_out/alu_CO/alu_OVF/alu_Z/alu_N (ALU results), done/result/flags (writeback status).
interface alu_exec_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  // Request channel
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_rd;
  logic [AW-1:0] req_rn;
  logic [AW-1:0] req_rm;
  logic          req_setf;

  // ALU operand side (driven by the sequencer)
  logic [DW-1:0] alu_A;
  logic [DW-1:0] alu_B;
  logic [2:0]    alu_ctrl;

  // ALU result side (driven by the ALU)
  logic [DW-1:0] alu_out;
  logic          alu_CO;
  logic          alu_OVF;
  logic          alu_Z;
  logic          alu_N;

  // Writeback status
  logic          done;
  logic [DW-1:0] result;
  logic [3:0]    flags;

  // Sequencer view
  modport slave (
    input  req_valid, req_op, req_rd, req_rn, req_rm, req_setf,
    output req_ready,
    output alu_A, alu_B, alu_ctrl,
    input  alu_out, alu_CO, alu_OVF, alu_Z, alu_N,
    output done, result, flags
  );

  // Requester / ALU / observer view
  modport master (
    output req_valid, req_op, req_rd, req_rn, req_rm, req_setf,
    input  req_ready,
    input  alu_A, alu_B, alu_ctrl,
    output alu_out, alu_CO, alu_OVF, alu_Z, alu_N,
    input  done, result, flags
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Purpose: operand/writeback sequencer around a combinational ALU with a 2**AW x DW regfile.
// Latency: accept edge -> done-high cycle is 3 cycles (READ, EXEC, WB); 1 op per 4 cycles.
// Backpressure: req_ready is high only in IDLE; requests must be held until accepted.
// Ports: clk, reset (sync, active-high); bus (alu_exec_ctrl_if.slave: request, ALU
//   operands/results, done/result/flags); ext_we/ext_waddr/ext_wdata (preload write,
//   IDLE only); dbg_raddr/dbg_rdata (combinational regfile read).
// The ALU itself is external; it is built with W = DW-1 so its data width matches DW.
module alu_exec_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  alu_exec_ctrl_if.slave bus,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_waddr,
  input  logic [DW-1:0] ext_wdata,
  input  logic [AW-1:0] dbg_raddr,
  output logic [DW-1:0] dbg_rdata
);

  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched request
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rn_q, rm_q;
  logic          setf_q;

  // ALU operand registers
  logic [DW-1:0] alu_a_q, alu_b_q;
  logic [2:0]    alu_ctrl_q;

  // EXEC capture of ALU outputs, flags packed {N,Z,C,V}
  logic [DW-1:0] cap_res_q;
  logic [3:0]    cap_flg_q;

  // Architectural outputs
  logic [DW-1:0] result_q;
  logic [3:0]    flags_q;

  logic [DW-1:0] regs_q [NREG];

  // Decoded per-cycle actions
  logic accept, do_read, do_exec, do_wb, ext_wr;

  // ---------------------------------------------------------------------------
  // Next-state and action decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    do_read = 1'b0;
    do_exec = 1'b0;
    do_wb   = 1'b0;
    ext_wr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Preload writes are only legal here, so they never race a writeback.
        ext_wr = ext_we;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        do_read = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        do_exec = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        do_wb   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch, operand fetch and ALU capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      rd_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      setf_q     <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      cap_res_q  <= '0;
      cap_flg_q  <= '0;
    end else begin
      if (accept) begin
        op_q   <= bus.req_op;
        rd_q   <= bus.req_rd;
        rn_q   <= bus.req_rn;
        rm_q   <= bus.req_rm;
        setf_q <= bus.req_setf;
      end
      // Operands come from the regfile one edge after accept, so a preload that
      // commits on the accept edge is already visible here.
      if (do_read) begin
        alu_a_q    <= regs_q[rn_q];
        alu_b_q    <= regs_q[rm_q];
        alu_ctrl_q <= op_q;
      end
      if (do_exec) begin
        cap_res_q <= bus.alu_out;
        cap_flg_q <= {bus.alu_N, bus.alu_Z, bus.alu_CO, bus.alu_OVF};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file and writeback
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      // do_wb and ext_wr are decoded from different states, never both high.
      if (do_wb) begin
        regs_q[rd_q] <= cap_res_q;
        result_q     <= cap_res_q;
        if (setf_q) begin
          flags_q <= cap_flg_q;
        end
      end else if (ext_wr) begin
        regs_q[ext_waddr] <= ext_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.alu_A     = alu_a_q;
  assign bus.alu_B     = alu_b_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  // High for the whole WB cycle; the regfile/result update lands on the edge ending it.
  assign bus.done      = (state_q == S_WB);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign dbg_rdata     = regs_q[dbg_raddr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Purpose: directed self-checking bench for alu_exec_ctrl with a behavioural ALU.
// Latency: checks accept-to-done of 3 cycles and state visible the cycle after done.
// Backpressure: waits (bounded) on req_ready before each request.
module tb_alu_exec_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          ext_we;
  logic [AW-1:0] ext_waddr;
  logic [DW-1:0] ext_wdata;
  logic [AW-1:0] dbg_raddr;
  logic [DW-1:0] dbg_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] val;
    logic [3:0]    flg;
  } exp_t;

  exp_t sb[$];

  alu_exec_ctrl_if #(.DW(DW), .AW(AW)) ifc ();

  alu_exec_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifc),
    .ext_we    (ext_we),
    .ext_waddr (ext_waddr),
    .ext_wdata (ext_wdata),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 000 ADD, 001 SUB (C = no borrow), 010 B-A, 011 AND, 100 OR,
  // 101 XOR, 110 NOR, 111 NOT A. Logic ops report C=V=0.
  always_comb begin
    logic [8:0] s9;
    logic [7:0] a, b, r;
    logic       c, v;
    a  = ifc.alu_A;
    b  = ifc.alu_B;
    s9 = '0;
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    case (ifc.alu_ctrl)
      3'b000: begin
        s9 = {1'b0, a} + {1'b0, b};
        r  = s9[7:0];
        c  = s9[8];
        v  = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'b001: begin
        r = a - b;
        c = (a >= b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'b010: begin
        r = b - a;
        c = (b >= a);
        v = (a[7] != b[7]) && (r[7] != b[7]);
      end
      3'b011:  r = a & b;
      3'b100:  r = a | b;
      3'b101:  r = a ^ b;
      3'b110:  r = ~(a | b);
      default: r = ~a;
    endcase
    ifc.alu_out = r;
    ifc.alu_CO  = c;
    ifc.alu_OVF = v;
    ifc.alu_Z   = (r == 8'h00);
    ifc.alu_N   = r[7];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ext_we    = 1'b1;
    ext_waddr = a;
    ext_wdata = d;
    @(negedge clk);
    ext_we    = 1'b0;
  endtask

  // ext_mode: 0 no preload write, 1 ext_we on the accept edge,
  // 2 ext_we held through READ/EXEC/WB (ext_waddr/ext_wdata set by caller).
  task automatic run_op(input string tag, input logic [2:0] op, input logic [AW-1:0] rd,
                        input logic [AW-1:0] rn, input logic [AW-1:0] rm, input logic setf,
                        input int ext_mode, input logic [DW-1:0] ev, input logic [3:0] ef);
    int   n;
    bit   seen;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!ifc.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, ifc.req_ready, 1);
    ifc.req_op    = op;
    ifc.req_rd    = rd;
    ifc.req_rn    = rn;
    ifc.req_rm    = rm;
    ifc.req_setf  = setf;
    ifc.req_valid = 1'b1;
    if (ext_mode == 1) ext_we = 1'b1;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    ext_we = (ext_mode == 2);
    e.rd  = rd;
    e.val = ev;
    e.flg = ef;
    sb.push_back(e);
    seen = 0;
    n    = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (ifc.done) seen = 1;
    end
    ext_we = 1'b0;
    chk({tag, "_latency"}, n, 3);
    e = sb.pop_front();
    dbg_raddr = e.rd;
    @(negedge clk);
    chk({tag, "_done_pulse"}, ifc.done, 0);
    chk({tag, "_result"}, ifc.result, e.val);
    chk({tag, "_flags"}, ifc.flags, e.flg);
    chk({tag, "_rd"}, dbg_rdata, e.val);
  endtask

  initial begin
    int dcnt;
    reset         = 1'b1;
    ext_we        = 1'b0;
    ext_waddr     = '0;
    ext_wdata     = '0;
    dbg_raddr     = '0;
    ifc.req_valid = 1'b0;
    ifc.req_op    = '0;
    ifc.req_rd    = '0;
    ifc.req_rn    = '0;
    ifc.req_rm    = '0;
    ifc.req_setf  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1. Reset state
    for (int i = 0; i < (1 << AW); i++) begin
      dbg_raddr = AW'(i);
      #1;
      chk($sformatf("reset_r%0d", i), dbg_rdata, 0);
    end
    chk("reset_flags", ifc.flags, 4'b0000);
    chk("reset_ready", ifc.req_ready, 1);
    chk("reset_done", ifc.done, 0);
    chk("reset_result", ifc.result, 0);
    chk("reset_aluA", ifc.alu_A, 0);
    chk("reset_aluB", ifc.alu_B, 0);
    chk("reset_ctrl", ifc.alu_ctrl, 0);

    // 2. 5 + 3
    preload(3'd1, 8'h05);
    preload(3'd2, 8'h03);
    run_op("add_basic", 3'b000, 3'd3, 3'd1, 3'd2, 1'b1, 0, 8'h08, 4'b0000);

    // 3. signed overflow 7F + 01
    preload(3'd1, 8'h7F);
    preload(3'd2, 8'h01);
    run_op("add_ovf", 3'b000, 3'd3, 3'd1, 3'd2, 1'b1, 0, 8'h80, 4'b1001);

    // 4. rd = rn = rm, setf=0 keeps flags; then setf=1 gives Z (and no-borrow C)
    preload(3'd1, 8'h05);
    run_op("sub_noflag", 3'b001, 3'd1, 3'd1, 3'd1, 1'b0, 0, 8'h00, 4'b1001);
    run_op("sub_flag", 3'b001, 3'd1, 3'd1, 3'd1, 1'b1, 0, 8'h00, 4'b0110);

    // Logic op with rd == rn, then a dependent op reading that result
    preload(3'd5, 8'hF0);
    preload(3'd6, 8'h3C);
    run_op("and_op", 3'b011, 3'd5, 3'd5, 3'd6, 1'b1, 0, 8'h30, 4'b0000);
    run_op("dep_add", 3'b000, 3'd2, 3'd5, 3'd5, 1'b1, 0, 8'h60, 4'b0000);

    // 5a. preload attempts while busy are ignored
    preload(3'd4, 8'h11);
    ext_waddr = 3'd4;
    ext_wdata = 8'hAA;
    run_op("busy_ext", 3'b000, 3'd7, 3'd1, 3'd5, 1'b1, 2, 8'h30, 4'b0000);
    dbg_raddr = 3'd4;
    #1;
    chk("busy_ext_r4", dbg_rdata, 8'h11);

    // 5b. preload on the accept edge is seen by READ: 60 - 40
    ext_waddr = 3'd6;
    ext_wdata = 8'h40;
    run_op("accept_ext", 3'b001, 3'd7, 3'd2, 3'd6, 1'b1, 1, 8'h20, 4'b0010);
    dbg_raddr = 3'd6;
    #1;
    chk("accept_ext_r6", dbg_rdata, 8'h40);

    // 6. reset during EXEC drops the writeback
    @(negedge clk);
    ifc.req_op    = 3'b000;
    ifc.req_rd    = 3'd3;
    ifc.req_rn    = 3'd1;
    ifc.req_rm    = 3'd2;
    ifc.req_setf  = 1'b1;
    ifc.req_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    @(negedge clk);  // READ
    @(negedge clk);  // EXEC
    reset = 1'b1;
    dcnt  = 0;
    @(negedge clk);
    reset = 1'b0;
    if (ifc.done) dcnt++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifc.done) dcnt++;
    end
    dbg_raddr = 3'd3;
    #1;
    chk("rst_mid_no_done", dcnt, 0);
    chk("rst_mid_ready", ifc.req_ready, 1);
    chk("rst_mid_flags", ifc.flags, 4'b0000);
    chk("rst_mid_result", ifc.result, 0);
    chk("rst_mid_r3", dbg_rdata, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
